// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM and PC owner for the RV32I core.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic [4:0]  rd,
  input  logic [4:0]  alu_control,
  input  logic [2:0]  load_control,
  input  logic [2:0]  store_control,
  input  logic [2:0]  branch_control,
  input  logic [1:0]  jump_control,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  state_t state, state_n;
  logic [31:0] next_pc, exec_pc;
  logic [6:0] opcode;
  logic legal, is_load, is_mem, is_branch, is_jump, redirect, misaligned, retire;
  logic unused_ctrl;
  assign unused_ctrl = ^{alu_control, load_control};
  assign opcode = ir[6:0];
  assign legal = opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  assign is_load = opcode == OP_LOAD;
  assign is_mem = is_load || opcode == OP_STORE;
  assign is_branch = opcode == OP_BRANCH;
  assign is_jump = opcode == OP_JAL || opcode == OP_JALR;
  assign redirect = jump_control != 2'd0 || (branch_control != 3'd0 && branch_taken);
  assign misaligned = redirect && target_addr[1:0] != 2'b00;
  assign exec_pc = redirect ? target_addr : pc + 32'd4;
  assign retire = state != FETCH && state_n == FETCH;
  assign imem_addr = pc;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = imem_ack ? DECODE : FETCH;
      DECODE:  state_n = legal ? EXEC : HALT;
      EXEC:    state_n = misaligned ? HALT : is_mem ? MEM : is_branch ? FETCH : WB;
      MEM:     state_n = !dmem_ack ? MEM : is_load ? WB : FETCH;
      WB:      state_n = FETCH;
      default: state_n = HALT;
    endcase
  end
  // Strobes are gated by rst_n so a pending request drops in the reset cycle itself.
  always_comb begin
    imem_req = rst_n && state == FETCH;
    alu_en = rst_n && state == EXEC;
    dmem_req = rst_n && state == MEM;
    dmem_we = dmem_req && store_control != 3'd0;
    rf_we = rst_n && state == WB && rd != 5'd0;
    rf_wsel = state != WB ? 2'd0 : is_load ? 2'd1 : is_jump ? 2'd2 : 2'd0;
    trap = state == HALT;
  end
  // Branches retire straight out of EXEC, so the PC takes the live value there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      next_pc <= RESET_PC;
      ir <= 32'h0000_0013;
      instret <= 32'd0;
      trap_cause <= 2'd0;
    end else begin
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (state == EXEC) next_pc <= exec_pc;
      if (retire) pc <= state == EXEC ? exec_pc : next_pc;
      if (retire) instret <= instret + 32'd1;
      if (state == DECODE && !legal) trap_cause <= 2'd1;
      if (state == EXEC && misaligned) trap_cause <= 2'd2;
    end
  end
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table vectors, corner sequences and random instruction streams for core_sequencer.
module tb_core_sequencer;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_ack = 0, alu_en, dmem_req, dmem_we, dmem_ack = 0, rf_we, trap, branch_taken = 0;
  logic [31:0] imem_addr, imem_rdata = 0, ir, pc, instret, target_addr = 0;
  logic [4:0] rd, alu_control;
  logic [2:0] load_control, store_control, branch_control;
  logic [1:0] jump_control, rf_wsel, trap_cause;
  int errors = 0, checks = 0;
  logic [31:0] m_pc = 0, m_instret = 0;

  typedef struct {
    logic [31:0] word; int iw; int dw; logic tk; logic [31:0] tgt;
    int cyc; int nwe; logic [1:0] wsel; logic dwe; logic [31:0] pc; logic [31:0] instret;
  } vec_t;
  vec_t tbl[12];
  logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  always #5 clk = ~clk;

  core_sequencer #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .pc(pc), .rd(rd), .alu_control(alu_control),
    .load_control(load_control), .store_control(store_control), .branch_control(branch_control),
    .jump_control(jump_control), .branch_taken(branch_taken), .target_addr(target_addr),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .rf_wsel(rf_wsel), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  // Minimal stand-in for idu, derived from the opcode field of ir
  assign rd = ir[11:7];
  assign alu_control = 5'd0;
  assign load_control = ir[6:0] == 7'h03 ? 3'd1 : 3'd0;
  assign store_control = ir[6:0] == 7'h23 ? 3'd2 : 3'd0;
  assign branch_control = ir[6:0] == 7'h63 ? 3'd1 : 3'd0;
  assign jump_control = ir[6:0] == 7'h6F ? 2'd1 : ir[6:0] == 7'h67 ? 2'd2 : 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 0; imem_ack = 0; dmem_ack = 0;
    @(negedge clk);
    chk("reset_strobes", 32'({imem_req, dmem_req, dmem_we, rf_we, alu_en, rf_wsel}), 32'd0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_ir", ir, 32'h0000_0013);
    chk("reset_instret", instret, 32'd0);
    chk("reset_trap", 32'({trap, trap_cause}), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("reset_fetch", 32'({imem_req, dmem_req}), 32'b10);
    chk("reset_imem_addr", imem_addr, 32'h0);
    m_pc = 0; m_instret = 0;
  endtask

  // Plays imem/dmem with the given wait states from one FETCH until the next FETCH or a trap.
  task automatic run_instr(input logic [31:0] word, input int iw, input int dw, input logic tk,
                           input logic [31:0] tgt, output int cyc, output int nwe, output int wec,
                           output logic [1:0] wsel, output logic dwe, output logic trapped);
    int fc, mc;
    logic left_fetch, done, unstable;
    logic [31:0] a0;
    cyc = 0; nwe = 0; wec = 0; wsel = 0; dwe = 0; trapped = 0;
    fc = 0; mc = 0; left_fetch = 0; done = 0; unstable = 0; a0 = imem_addr;
    branch_taken = tk; target_addr = tgt; imem_rdata = word;
    for (int k = 0; k < 200 && !done; k++) begin
      if (trap) begin
        trapped = 1; done = 1;
      end else if (imem_req && left_fetch) begin
        done = 1;
      end else begin
        cyc++;
        if (imem_req && dmem_req) unstable = 1;
        if (imem_req && imem_addr !== a0) unstable = 1;
        if (!imem_req) left_fetch = 1;
        if (rf_we) begin nwe++; wec = cyc; wsel = rf_wsel; end
        imem_ack = imem_req && fc == iw;
        if (imem_req) fc++;
        if (dmem_req) begin
          if (mc == 0) dwe = dmem_we;
          else if (dmem_we !== dwe) unstable = 1;
          dmem_ack = mc == dw;
          mc++;
        end else dmem_ack = 0;
        @(negedge clk);
      end
    end
    imem_ack = 0; dmem_ack = 0;
    chk("instr_timeout", 32'(done), 32'd1);
    chk("req_stable", 32'(unstable), 32'd0);
  endtask

  // Reference: per-instruction cycle totals and effects from the opcode class alone.
  task automatic model(input logic [31:0] word, input logic tk, input logic [31:0] tgt, input int iw,
                       input int dw, output int cyc, output int nwe, output logic [1:0] wsel,
                       output logic dwe, output logic [1:0] cause, output logic [31:0] npc);
    logic [6:0] op;
    logic ld, st, br, jp, ok, redir;
    op = word[6:0];
    ld = op == 7'h03; st = op == 7'h23; br = op == 7'h63; jp = op == 7'h6F || op == 7'h67;
    ok = ld || st || br || jp || op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17;
    redir = jp || (br && tk);
    cause = !ok ? 2'd1 : (redir && tgt % 4 != 0) ? 2'd2 : 2'd0;
    cyc = (iw + 1) + 2 + ((ld || st) ? dw + 1 : 0) + ((br || st) ? 0 : 1);
    nwe = (!br && !st && word[11:7] != 0) ? 1 : 0;
    wsel = ld ? 2'd1 : jp ? 2'd2 : 2'd0;
    dwe = st;
    npc = redir ? tgt : m_pc + 32'd4;
  endtask

  task automatic step(input logic [31:0] word, input int iw, input int dw, input logic tk, input logic [31:0] tgt);
    int cyc, nwe, wec, e_cyc, e_nwe;
    logic [1:0] wsel, e_wsel, e_cause;
    logic dwe, e_dwe, trapped;
    logic [31:0] e_pc;
    model(word, tk, tgt, iw, dw, e_cyc, e_nwe, e_wsel, e_dwe, e_cause, e_pc);
    run_instr(word, iw, dw, tk, tgt, cyc, nwe, wec, wsel, dwe, trapped);
    chk("trap", 32'(trapped), 32'(e_cause != 0));
    if (trapped) begin
      chk("trap_cause", 32'(trap_cause), 32'(e_cause));
      chk("halt_pc", pc, m_pc);
      chk("halt_instret", instret, m_instret);
      for (int k = 0; k < 4; k++) begin
        chk("halt_quiet", 32'({imem_req, dmem_req, rf_we, alu_en}), 32'd0);
        @(negedge clk);
      end
      chk("halt_pc_frozen", pc, m_pc);
      do_reset();
    end else begin
      chk("cycles", 32'(cyc), 32'(e_cyc));
      chk("rf_we_count", 32'(nwe), 32'(e_nwe));
      chk("dmem_we", 32'(dwe), 32'(e_dwe));
      if (e_nwe != 0 && nwe != 0) begin
        chk("rf_wsel", 32'(wsel), 32'(e_wsel));
        chk("rf_we_in_last_cycle", 32'(wec), 32'(e_cyc));
      end
      m_pc = e_pc; m_instret = m_instret + 1;
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("instret", instret, m_instret);
    end
  endtask

  initial begin
    int cyc, nwe, wec;
    logic [1:0] wsel;
    logic dwe, trapped;
    logic [31:0] w, t;
    tbl = '{
      '{32'h0050_0093, 0, 0, 1'b0, 32'h0,         4, 1, 2'd0, 1'b0, 32'h4,         32'd1},
      '{32'h0010_8133, 1, 0, 1'b0, 32'h0,         5, 1, 2'd0, 1'b0, 32'h8,         32'd2},
      '{32'h0000_0063, 0, 0, 1'b1, 32'h40,        3, 0, 2'd0, 1'b0, 32'h40,        32'd3},
      '{32'h0000_2183, 3, 2, 1'b0, 32'h0,        10, 1, 2'd1, 1'b0, 32'h44,        32'd4},
      '{32'h0030_2023, 0, 1, 1'b0, 32'h0,         5, 0, 2'd0, 1'b1, 32'h48,        32'd5},
      '{32'h0000_006F, 0, 0, 1'b0, 32'h100,       4, 0, 2'd0, 1'b0, 32'h100,       32'd6},
      '{32'h0000_00EF, 0, 0, 1'b0, 32'h200,       4, 1, 2'd2, 1'b0, 32'h200,       32'd7},
      '{32'h0000_02B7, 0, 0, 1'b0, 32'h0,         4, 1, 2'd0, 1'b0, 32'h204,       32'd8},
      '{32'h0000_1063, 0, 0, 1'b0, 32'h123,       3, 0, 2'd0, 1'b0, 32'h208,       32'd9},
      '{32'h0000_006F, 0, 0, 1'b0, 32'hFFFF_FFFC, 4, 0, 2'd0, 1'b0, 32'hFFFF_FFFC, 32'd10},
      '{32'h0050_0093, 0, 0, 1'b0, 32'h0,         4, 1, 2'd0, 1'b0, 32'h0,         32'd11},
      '{32'h0000_0017, 0, 0, 1'b0, 32'h0,         4, 0, 2'd0, 1'b0, 32'h4,         32'd12}
    };
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].word, tbl[i].iw, tbl[i].dw, tbl[i].tk, tbl[i].tgt, cyc, nwe, wec, wsel, dwe, trapped);
      chk($sformatf("tbl%0d_trap", i), 32'(trapped), 32'd0);
      chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_rf_we", i), 32'(nwe), 32'(tbl[i].nwe));
      if (tbl[i].nwe != 0) begin
        chk($sformatf("tbl%0d_rf_wsel", i), 32'(wsel), 32'(tbl[i].wsel));
        chk($sformatf("tbl%0d_wb_cycle", i), 32'(wec), 32'(tbl[i].cyc));
      end
      chk($sformatf("tbl%0d_dmem_we", i), 32'(dwe), 32'(tbl[i].dwe));
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("tbl%0d_imem_addr", i), imem_addr, tbl[i].pc);
      chk($sformatf("tbl%0d_instret", i), instret, tbl[i].instret);
      m_pc = tbl[i].pc; m_instret = tbl[i].instret;
    end
    step(32'h0050_0093, 0, 0, 1'b0, 32'h0);
    step(32'h0000_006F, 0, 0, 1'b0, 32'h102);
    step(32'h0050_0093, 1, 0, 1'b0, 32'h0);
    step(32'hFFFF_FFFF, 2, 0, 1'b0, 32'h0);
    step(32'h0050_0093, 0, 0, 1'b0, 32'h0);
    // Reset while a load waits on dmem; the ack arriving at that edge must be dropped
    imem_rdata = 32'h0000_2183; imem_ack = 1;
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    chk("stale_dmem_req", 32'({dmem_req, dmem_we}), 32'b10);
    rst_n = 0; dmem_ack = 1;
    @(negedge clk);
    chk("stale_req_drop", 32'({imem_req, dmem_req}), 32'd0);
    rst_n = 1;
    @(negedge clk);
    dmem_ack = 0;
    chk("stale_fetch", 32'({imem_req, dmem_req, rf_we}), 32'b100);
    chk("stale_addr", imem_addr, 32'h0);
    chk("stale_instret", instret, 32'd0);
    m_pc = 0; m_instret = 0;
    step(32'h0050_0093, 0, 0, 1'b0, 32'h0);
    for (int i = 0; i < 60; i++) begin
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 9)];
      t = $urandom();
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      step(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for the single-issue RV32I core.
- Fetches an instruction over the imem handshake and latches it into the instruction register that drives idu.
- Consumes idu's decoded controls, then steps the execute, memory and writeback phases and owns the PC.
- Sits between the memory ports and the idu/ALU/regfile datapath; it is the only block that advances architectural state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst_n  in  1  reset; synchronous, active-low.
imem_req  out  1  instruction fetch request.
imem_addr  out  32  fetch address; equals pc.
imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction word.
ir  out  32  instruction register; feeds idu instruction_code.
pc  out  32  architectural PC of the instruction in ir.
rd  in  5  destination register from idu.
alu_control  in  5  from idu.
load_control  in  3  from idu.
store_control  in  3  from idu.
branch_control  in  3  from idu.
jump_control  in  2  from idu.
branch_taken  in  1  ALU compare result; valid in EXEC.
target_addr  in  32  branch/jump target from datapath; valid in EXEC.
alu_en  out  1  ALU operands/result capture strobe.
dmem_req  out  1  data memory request.
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
dmem_ack  in  1  data access complete.
rf_we  out  1  register file write enable.
rf_wsel  out  2  writeback source: 0 = ALU, 1 = load data, 2 = pc+4.
instret  out  32  retired-instruction counter.
trap  out  1  sticky halt flag.
trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = misaligned target.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc=RESET_PC, ir=32'h0000_0013 (NOP), instret=0, trap=0, trap_cause=0, state=FETCH.
  - All strobes (imem_req, dmem_req, dmem_we, rf_we, alu_en) = 0; rf_wsel=0.
  - Reset mid-transaction abandons any outstanding imem/dmem request; the ack is ignored in the cycle reset is applied.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc, held until imem_ack.
  - On ack: ir<=imem_rdata, go to DECODE.
  - Ack in the first request cycle is legal (1-cycle fetch).
- DECODE:
  - One cycle; idu settles combinationally on ir.
  - Opcode ir[6:0] not in {REG, IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC} -> HALT with trap_cause=1.
  - Otherwise go to EXEC.
- EXEC:
  - alu_en=1 for one cycle.
  - Redirect = jump_control != JMP_NOP, or (branch_control != BR_NOP and branch_taken).
  - If redirect and target_addr[1:0] != 0 -> HALT with trap_cause=2.
  - Otherwise latch next_pc: target_addr on redirect, else pc+4 (32-bit, wraps modulo 2^32).
  - Next state: load or store -> MEM; BRANCH -> retire directly to FETCH (no WB); all other opcodes -> WB.
- MEM:
  - dmem_req=1, dmem_we = (store_control != STR_NOP), both held stable until dmem_ack.
  - On ack: load -> WB; store -> retire to FETCH.
- WB:
  - One cycle.
  - rf_we=1 only if rd != 0; rd=0 suppresses the write but still retires.
  - rf_wsel=1 for loads, 2 for JAL/JALR, 0 otherwise.
  - Retire, then go to FETCH.
- Retire: pc<=next_pc and instret<=instret+1 (wraps) in the same edge the state returns to FETCH.
- HALT:
  - trap=1, all strobes 0; pc, ir and instret frozen.
  - Left only by reset.
- Latency (zero-wait memories):
  - ALU op: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Signal properties:
  - imem_req and dmem_req are never high in the same cycle.
  - rf_we is only ever high in WB.

Test Plan:
- Reset then zero-wait imem returning ADDI x1,x0,5 (32'h0050_0093): imem_addr=0; rf_we=1 with rf_wsel=0 in cycle 4; pc=4, instret=1 after retire.
- BEQ taken (branch_taken=1, target_addr=32'h40) at pc=8: no rf_we pulse; next imem_addr=32'h40; retire after 3 cycles.
- LW with imem_ack delayed 3 cycles and dmem_ack delayed 2 cycles: imem_req and dmem_req held stable throughout; dmem_we=0; rf_wsel=1; rf_we exactly one cycle.
- JAL with rd=0 to target 32'h100: rf_we stays 0; pc=32'h100; instret increments.
- Illegal word 32'hFFFF_FFFF: HALT with trap=1, trap_cause=1; no further imem_req; pc frozen; rst_n=0 for one edge restores pc=RESET_PC and trap=0.
- Taken jump to target_addr=32'h102: trap_cause=2 and pc unchanged. Separately, assert rst_n=0 while dmem_req=1: FETCH at RESET_PC next cycle and the stale dmem_ack is ignored.
